// File: rtl/regfile_if.sv
// Bus bundle between the MIPS32 ID/WB stages and the register file:
// WB write, two ID read ports, debug read and the retired-write counter.
interface regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [CNT_W-1:0]  wr_cnt;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_addr,
    input  rdata1, rdata2, dbg_data, wr_cnt
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_addr,
    output rdata1, rdata2, dbg_data, wr_cnt
  );
endinterface

// File: rtl/regfile.sv
// MIPS32 general-purpose register file: r0 hardwired to zero, two combinational
// read ports with write-through bypass, debug read of committed state, write counter.
module regfile_rd_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                               rst,
  input  logic                               re,
  input  logic [ADDR_W-1:0]                  raddr,
  input  logic                               we,
  input  logic [ADDR_W-1:0]                  waddr,
  input  logic [DATA_W-1:0]                  wdata,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]    regs,
  output logic [DATA_W-1:0]                  rdata
);
  always_comb begin
    rdata = '0;
    if (rst || raddr == '0)
      rdata = '0;
    else if (re && we && waddr == raddr)
      rdata = wdata;
    else if (re)
      rdata = regs[raddr];
  end
endmodule

module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);
  localparam int NUM_RD = 2;

  // Entry 0 is never written, so it stays at its reset value of zero.
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [CNT_W-1:0]                cnt;
  logic                            wr_ok;

  assign wr_ok = bus.we && (bus.waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
      cnt  <= '0;
    end else if (wr_ok) begin
      regs[bus.waddr] <= bus.wdata;
      cnt             <= cnt + CNT_W'(1);
    end
  end

  logic [NUM_RD-1:0]             re;
  logic [NUM_RD-1:0][ADDR_W-1:0] raddr;
  logic [NUM_RD-1:0][DATA_W-1:0] rdata;

  assign re    = {bus.re2, bus.re1};
  assign raddr = {bus.raddr2, bus.raddr1};

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_REGS(NUM_REGS)
    ) u_rd (
      .rst  (rst),
      .re   (re[i]),
      .raddr(raddr[i]),
      .we   (bus.we),
      .waddr(bus.waddr),
      .wdata(bus.wdata),
      .regs (regs),
      .rdata(rdata[i])
    );
  end

  assign bus.rdata1   = rdata[0];
  assign bus.rdata2   = rdata[1];
  // Debug view deliberately skips the bypass: it shows committed state only.
  assign bus.dbg_data = rst ? '0 : regs[bus.dbg_addr];
  assign bus.wr_cnt   = cnt;
endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic
// compared against an array-based architectural model.
module tb_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) b();
  regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  b4();

  regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(b)
  );
  regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(b4)
  );

  logic [31:0] model [32];
  int unsigned wcount;
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [31:0] exp_rd(logic en, logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
    if (en && b.we && b.waddr == a) return b.wdata;
    if (en) return model[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] exp_dbg(logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
    return model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    wcount = 0;
  endtask

  task automatic drive(logic we, logic [4:0] wa, logic [31:0] wd,
                       logic r1, logic [4:0] a1, logic r2, logic [4:0] a2,
                       logic [4:0] da);
    b.we = we; b.waddr = wa; b.wdata = wd;
    b.re1 = r1; b.raddr1 = a1; b.re2 = r2; b.raddr2 = a2; b.dbg_addr = da;
  endtask

  // Advance one clock: apply architectural effect of the edge, return at negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else if (b.we && b.waddr != 5'd0) begin
      model[b.waddr] = b.wdata;
      wcount++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd5, 1'b1, 5'd5, 5'd5);
    @(negedge clk);
    #1;
    n_cmp++; if (b.rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1_bypass: got %h want %h", b.rdata1, 32'h0); end
    n_cmp++; if (b.dbg_data !== 32'h0) begin n_fail++; $display("FAIL reset_dbg: got %h want %h", b.dbg_data, 32'h0); end
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0, 5'd5);
    #1;
    n_cmp++; if (b.rdata1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd_r5: got %h want %h", b.rdata1, 32'h0); end
    n_cmp++; if (b.wr_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_wr_cnt: got %0d want %0d", b.wr_cnt, 0); end
  endtask

  task automatic test_write_read();
    drive(1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd3);
    #1;
    n_cmp++; if (b.rdata1 !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_rd1: got %h want %h", b.rdata1, 32'h1234_5678); end
    n_cmp++; if (b.wr_cnt !== 32'd1) begin n_fail++; $display("FAIL wr_cnt1: got %0d want %0d", b.wr_cnt, 1); end
    n_cmp++; if (b.dbg_data !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_dbg: got %h want %h", b.dbg_data, 32'h1234_5678); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7);
    #1;
    n_cmp++; if (b.rdata1 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL byp_rd1: got %h want %h", b.rdata1, 32'hA5A5_A5A5); end
    n_cmp++; if (b.rdata2 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL byp_rd2: got %h want %h", b.rdata2, 32'hA5A5_A5A5); end
    n_cmp++; if (b.dbg_data !== 32'h0) begin n_fail++; $display("FAIL byp_dbg_old: got %h want %h", b.dbg_data, 32'h0); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd3, 5'd7);
    #1;
    n_cmp++; if (b.dbg_data !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL byp_dbg_new: got %h want %h", b.dbg_data, 32'hA5A5_A5A5); end
    n_cmp++; if (b.rdata2 !== 32'h1234_5678) begin n_fail++; $display("FAIL byp_rd2_r3: got %h want %h", b.rdata2, 32'h1234_5678); end
    n_cmp++; if (b.wr_cnt !== 32'd2) begin n_fail++; $display("FAIL byp_cnt: got %0d want %0d", b.wr_cnt, 2); end
  endtask

  task automatic test_r0();
    drive(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
    #1;
    n_cmp++; if (b.rdata1 !== 32'h0) begin n_fail++; $display("FAIL r0_rd1_same: got %h want %h", b.rdata1, 32'h0); end
    n_cmp++; if (b.rdata2 !== 32'h0) begin n_fail++; $display("FAIL r0_rd2_same: got %h want %h", b.rdata2, 32'h0); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    #1;
    n_cmp++; if (b.rdata1 !== 32'h0) begin n_fail++; $display("FAIL r0_rd1_after: got %h want %h", b.rdata1, 32'h0); end
    n_cmp++; if (b.dbg_data !== 32'h0) begin n_fail++; $display("FAIL r0_dbg: got %h want %h", b.dbg_data, 32'h0); end
    n_cmp++; if (b.wr_cnt !== 32'd2) begin n_fail++; $display("FAIL r0_cnt: got %0d want %0d", b.wr_cnt, 2); end
  endtask

  task automatic test_read_disable();
    drive(1'b1, 5'd9, 32'h0000_00FF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9);
    #1;
    n_cmp++; if (b.rdata2 !== 32'h0) begin n_fail++; $display("FAIL rdis_off: got %h want %h", b.rdata2, 32'h0); end
    b.re2 = 1'b1;
    #1;
    n_cmp++; if (b.rdata2 !== 32'h0000_00FF) begin n_fail++; $display("FAIL rdis_on: got %h want %h", b.rdata2, 32'h0000_00FF); end
    drive(1'b1, 5'd9, 32'h5555_0000, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
    #1;
    n_cmp++; if (b.rdata2 !== 32'h0) begin n_fail++; $display("FAIL rdis_byp_off: got %h want %h", b.rdata2, 32'h0); end
    n_cmp++; if (b.rdata1 !== 32'h5555_0000) begin n_fail++; $display("FAIL rdis_byp_on: got %h want %h", b.rdata1, 32'h5555_0000); end
    tick();
  endtask

  task automatic test_reset_midstream();
    logic [31:0] d;
    for (int i = 1; i <= 31; i++) begin
      d = $urandom;
      drive(1'b1, 5'(i), d, 1'b1, 5'(i), 1'b1, 5'(i - 1), 5'(i - 1));
      #1;
      n_cmp++; if (b.rdata1 !== d) begin n_fail++; $display("FAIL ms_byp r%0d: got %h want %h", i, b.rdata1, d); end
      tick();
      if (i == 10) break;
    end
    // Reset lands between edges with a write still on the bus.
    drive(1'b1, 5'd11, 32'hCAFE_F00D, 1'b1, 5'd11, 1'b1, 5'd4, 5'd4);
    rst = 1'b1;
    #1;
    n_cmp++; if (b.wr_cnt !== 32'd0) begin n_fail++; $display("FAIL ms_cnt_now: got %0d want %0d", b.wr_cnt, 0); end
    for (int a = 1; a <= 10; a++) begin
      b.raddr1 = 5'(a); b.raddr2 = 5'(a); b.dbg_addr = 5'(a);
      #1;
      n_cmp++;
      if (b.rdata1 !== 32'h0 || b.rdata2 !== 32'h0 || b.dbg_data !== 32'h0) begin
        n_fail++;
        $display("FAIL ms_zero r%0d: got %h/%h/%h want 0", a, b.rdata1, b.rdata2, b.dbg_data);
      end
    end
    model_clear();
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd11, 5'd10);
    #1;
    n_cmp++; if (b.rdata1 !== 32'h0) begin n_fail++; $display("FAIL ms_r5_after: got %h want %h", b.rdata1, 32'h0); end
    n_cmp++; if (b.rdata2 !== 32'h0) begin n_fail++; $display("FAIL ms_r11_lost: got %h want %h", b.rdata2, 32'h0); end
    n_cmp++; if (b.dbg_data !== 32'h0) begin n_fail++; $display("FAIL ms_dbg_after: got %h want %h", b.dbg_data, 32'h0); end
    n_cmp++; if (b.wr_cnt !== 32'd0) begin n_fail++; $display("FAIL ms_cnt_after: got %0d want %0d", b.wr_cnt, 0); end
  endtask

  task automatic test_random();
    logic [4:0] wa;
    for (int n = 0; n < 400; n++) begin
      wa = 5'($urandom_range(0, 31));
      drive(1'($urandom), wa, $urandom,
            1'($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
      #1;
      n_cmp++; if (b.rdata1 !== exp_rd(b.re1, b.raddr1)) begin n_fail++; $display("FAIL rnd_rd1 #%0d: got %h want %h", n, b.rdata1, exp_rd(b.re1, b.raddr1)); end
      n_cmp++; if (b.rdata2 !== exp_rd(b.re2, b.raddr2)) begin n_fail++; $display("FAIL rnd_rd2 #%0d: got %h want %h", n, b.rdata2, exp_rd(b.re2, b.raddr2)); end
      n_cmp++; if (b.dbg_data !== exp_dbg(b.dbg_addr)) begin n_fail++; $display("FAIL rnd_dbg #%0d: got %h want %h", n, b.dbg_data, exp_dbg(b.dbg_addr)); end
      n_cmp++; if (b.wr_cnt !== wcount) begin n_fail++; $display("FAIL rnd_cnt #%0d: got %0d want %0d", n, b.wr_cnt, wcount); end
      tick();
    end
  endtask

  task automatic test_wrap();
    b.we = 1'b0;
    b4.re1 = 1'b0; b4.raddr1 = 5'd0; b4.re2 = 1'b0; b4.raddr2 = 5'd0; b4.dbg_addr = 5'd0;
    for (int k = 1; k <= 16; k++) begin
      b4.we = 1'b1; b4.waddr = 5'(((k - 1) % 31) + 1); b4.wdata = 32'(k);
      @(posedge clk); @(negedge clk);
      if (k == 15) begin
        n_cmp++; if (b4.wr_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap_15: got %0d want %0d", b4.wr_cnt, 15); end
        b4.waddr = 5'd0;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (b4.wr_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap_r0: got %0d want %0d", b4.wr_cnt, 15); end
      end
    end
    b4.we = 1'b0;
    n_cmp++; if (b4.wr_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_0: got %0d want %0d", b4.wr_cnt, 0); end
    #1;
    b4.dbg_addr = 5'd16;
    #1;
    n_cmp++; if (b4.dbg_data !== 32'd16) begin n_fail++; $display("FAIL wrap_dbg16: got %h want %h", b4.dbg_data, 32'd16); end
  endtask

  initial begin
    model_clear();
    b4.we = 1'b0; b4.waddr = 5'd0; b4.wdata = 32'h0;
    b4.re1 = 1'b0; b4.raddr1 = 5'd0; b4.re2 = 1'b0; b4.raddr2 = 5'd0; b4.dbg_addr = 5'd0;
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_read_disable();
    test_reset_midstream();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
